// File: rtl/i2c_slave_regif.sv
// I2C target with pointer-then-data register protocol: filtered SCL/SDA,
// 7-bit address match, auto-incrementing pointer, one-cycle REG_WR/REG_RD strobes.
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR = 7'h40,
  parameter int         FILT_LEN = 3
) (
  input  logic       SYSCLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WR,
  output logic       REG_RD,
  input  logic [7:0] REG_RDATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RLOAD, RDATA, RACK, IGNORE
  } state_t;

  // index 0 = SCL, 1 = SDA; idle bus level is high
  logic [1:0]      s1, s2, filt, filt_d;
  logic [1:0][2:0] cnt;

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      s1     <= '1;
      s2     <= '1;
      filt   <= '1;
      filt_d <= '1;
      cnt    <= '0;
    end else begin
      s1     <= {SDA_IN, SCL_IN};
      s2     <= s1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] != filt[i]) begin
          if (cnt[i] == 3'(FILT_LEN - 1)) begin
            filt[i] <= s2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 3'd1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_rise, scl_fall, start, stop;
  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_rise = scl_f & ~filt_d[0];
  assign scl_fall = ~scl_f & filt_d[0];
  assign start    = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
  assign stop     = scl_f & filt_d[0] & ~filt_d[1] & sda_f;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, ptr, ptr_n, reg_addr_n, reg_wdata_n, shin;
  logic       rd_pend, rd_pend_n, mack, mack_n;
  logic       sda_oe_n, busy_n, reg_wr_n, reg_rd_n;

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rd_pend   <= 1'b0;
      mack      <= 1'b1;
      SDA_OE    <= 1'b0;
      BUSY      <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_WR    <= 1'b0;
      REG_RD    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rd_pend   <= rd_pend_n;
      mack      <= mack_n;
      SDA_OE    <= sda_oe_n;
      BUSY      <= busy_n;
      REG_ADDR  <= reg_addr_n;
      REG_WDATA <= reg_wdata_n;
      REG_WR    <= reg_wr_n;
      REG_RD    <= reg_rd_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    ptr_n       = ptr;
    rd_pend_n   = rd_pend;
    mack_n      = mack;
    sda_oe_n    = SDA_OE;
    busy_n      = BUSY;
    reg_addr_n  = REG_ADDR;
    reg_wdata_n = REG_WDATA;
    reg_wr_n    = 1'b0;
    reg_rd_n    = 1'b0;
    shin        = {shreg[6:0], sda_f};
    if (start) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      rd_pend_n = 1'b0;
    end else if (stop) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
      rd_pend_n = 1'b0;
    end else begin
      case (state)
        ADDR, PTR, WDATA: if (scl_rise) begin
          shreg_n   = shin;
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            if (state == ADDR) begin
              if (shin[7:1] == DEV_ADDR) state_n = ADDR_ACK;
              else begin
                state_n = IGNORE;
                busy_n  = 1'b0;
              end
            end else if (state == PTR) begin
              ptr_n   = shin;
              state_n = PTR_ACK;
            end else begin
              reg_wr_n    = 1'b1;
              reg_addr_n  = ptr;
              reg_wdata_n = shin;
              state_n     = WDATA_ACK;
            end
          end
        end
        // ACK is driven from the 8th falling edge to the 9th
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!SDA_OE) begin
            sda_oe_n = 1'b1;
            if (state == ADDR_ACK) busy_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == ADDR_ACK) state_n = shreg[0] ? RLOAD : PTR;
            else state_n = WDATA;
            if (state == WDATA_ACK) ptr_n = ptr + 8'd1;
          end
        end
        RLOAD: begin
          if (!rd_pend) begin
            reg_rd_n   = 1'b1;
            reg_addr_n = ptr;
            rd_pend_n  = 1'b1;
          end else if (!REG_RD) begin
            rd_pend_n = 1'b0;
            sda_oe_n  = ~REG_RDATA[7];
            shreg_n   = {REG_RDATA[6:0], 1'b0};
            bit_cnt_n = 4'd1;
            state_n   = RDATA;
          end
        end
        RDATA: if (scl_fall) begin
          if (bit_cnt != 4'd8) begin
            sda_oe_n  = ~shreg[7];
            shreg_n   = {shreg[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
          end else begin
            sda_oe_n = 1'b0;
            state_n  = RACK;
          end
        end
        RACK: begin
          if (scl_rise) mack_n = sda_f;
          if (scl_fall) begin
            if (!mack) begin
              ptr_n   = ptr + 8'd1;
              state_n = RLOAD;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
